// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory address/data, branch redirect and decode handshake.
// master = fetch controller, slave = memory/execute/decode side.
interface imem_fetch_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      imem_address;
  logic [31:0]      imem_instruction;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             dec_ready;
  logic             inst_valid;
  logic [31:0]      inst;
  logic [31:0]      inst_pc;
  logic [CNT_W-1:0] fifo_count;
  logic             fault;

  modport master (
    output imem_address,
    input  imem_instruction,
    input  branch_taken,
    input  branch_target,
    input  dec_ready,
    output inst_valid,
    output inst,
    output inst_pc,
    output fifo_count,
    output fault
  );

  modport slave (
    input  imem_address,
    output imem_instruction,
    output branch_taken,
    output branch_target,
    output dec_ready,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  fifo_count,
    input  fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: drives PC to a zero-latency imem, queues {instr, pc} in a DEPTH-entry prefetch FIFO.
// Latency: first entry valid 2 edges after reset release or a taken branch. Backpressure: dec_ready stalls pushes once full.
// IMEM_FAULT_EN adds a sticky fault/HALT on misaligned or out-of-range fetch addresses.
module imem_fetch_ctrl #(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024
) (
  input logic              clk,
  input logic              rst_n,
  imem_fetch_ctrl_if.master bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [31:0]   PC_MASK  = 32'(IMEM_BYTES - 1);
`ifdef IMEM_FAULT_EN
  localparam logic [32:0]   PC_LIMIT = 33'(IMEM_BYTES);
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_ent_t;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_FETCH,
    ST_REDIRECT
`ifdef IMEM_FAULT_EN
    , ST_HALT
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_inc;
  logic        halted;
  logic        push, pop, flush;
  fetch_ent_t  push_ent;

  fetch_ent_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_ent_t  head_q, head_d;
  logic        fifo_vld;
  logic        do_push, do_pop;

`ifdef IMEM_FAULT_EN
  logic fault_q, fault_d;
  assign halted    = (state_q == ST_HALT);
  assign bus.fault = fault_q;
`else
  assign halted    = 1'b0;
  assign bus.fault = 1'b0;
`endif

  assign fifo_vld = (count_q != '0);
  assign pop      = fifo_vld && bus.dec_ready;
  assign pc_inc   = pc_q + 32'd4;
  assign push_ent = '{instr: bus.imem_instruction, pc: pc_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
`ifdef IMEM_FAULT_EN
    fault_d = fault_q;
`endif

    case (state_q)
      ST_WAIT:     state_d = ST_FETCH;
      ST_REDIRECT: state_d = ST_FETCH;
      ST_FETCH: begin
        // Full FIFO may still accept a push when the head leaves on the same edge.
        push = (count_q < FULL_CNT) || pop;
        if (push) begin
`ifdef IMEM_FAULT_EN
          if ({1'b0, pc_inc} >= PC_LIMIT) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d = pc_inc;
          end
`else
          pc_d = pc_inc & PC_MASK;
`endif
        end
      end
      default: state_d = state_q;
    endcase

    if (bus.branch_taken && !halted) begin
      flush = 1'b1;
      push  = 1'b0;
`ifdef IMEM_FAULT_EN
      if ((bus.branch_target[1:0] != 2'b00) || ({1'b0, bus.branch_target} >= PC_LIMIT)) begin
        fault_d = 1'b1;
        state_d = ST_HALT;
      end else begin
        pc_d    = bus.branch_target & ~32'd3;
        state_d = ST_REDIRECT;
      end
`else
      pc_d    = bus.branch_target & ~32'd3;
      state_d = ST_REDIRECT;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IMEM_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end
`endif

  // Prefetch FIFO; head_q mirrors the head slot so outputs never see imem combinationally.
  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      if (count_d != '0) begin
        if (do_push && (rd_ptr_d == wr_ptr_q)) begin
          head_d = push_ent;
        end else begin
          head_d = mem_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_ent;
      end
    end
  end

  assign bus.imem_address = pc_q;
  assign bus.inst_valid   = fifo_vld;
  assign bus.inst         = head_q.instr;
  assign bus.inst_pc      = head_q.pc;
  assign bus.fifo_count   = count_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized scoreboard bench for imem_fetch_ctrl; memory returns 0xE0000000 | address.
module tb_imem_fetch_ctrl;

  localparam int          DEPTH      = 4;
  localparam int          IMEM_BYTES = 1024;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          CW         = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst_n;

  imem_fetch_ctrl_if #(.DEPTH(DEPTH)) bus();

  imem_fetch_ctrl #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC),
    .IMEM_BYTES(IMEM_BYTES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_instruction = 32'hE000_0000 | bus.imem_address;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] cnt;
    logic [31:0]   addr;
    logic          flt;
  } st_t;

  st_t         st_q[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 0;

  // Reference model: the queue of fetched PCs, the next PC, pending bubble cycles, fault flag.
  logic [31:0] m_pc;
  int          m_hold;
  logic [31:0] m_q[$];
  bit          m_flt;

  st_t         mon_s;
  logic [31:0] mon_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc   = RESET_PC;
    m_hold = 1;
    m_q.delete();
    m_flt  = 0;
  endfunction

  function automatic void model_step(input bit rdy, input bit br, input logic [31:0] tgt);
    bit pop;
    pop = rdy && (m_q.size() > 0);
    if (m_flt) begin
      if (pop) void'(m_q.pop_front());
      return;
    end
    if (br) begin
      m_q.delete();
`ifdef IMEM_FAULT_EN
      if (tgt[1:0] != 2'b00 || tgt >= IMEM_BYTES) begin
        m_flt = 1;
        return;
      end
`endif
      m_pc   = tgt & ~32'd3;
      m_hold = 1;
      return;
    end
    if (m_hold > 0) begin
      m_hold--;
      if (pop) void'(m_q.pop_front());
      return;
    end
    if (m_q.size() < DEPTH || pop) begin
      if (pop) void'(m_q.pop_front());
      m_q.push_back(m_pc);
`ifdef IMEM_FAULT_EN
      if (m_pc + 4 >= IMEM_BYTES) m_flt = 1;
      else m_pc = m_pc + 4;
`else
      m_pc = (m_pc + 4) % IMEM_BYTES;
`endif
    end
  endfunction

  // Drive one cycle of inputs, record what the DUT must show during it, advance the model.
  task automatic cycle(input bit rdy, input bit br, input logic [31:0] tgt);
    st_t s;
    bus.dec_ready     = rdy;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    s.vld  = (m_q.size() > 0);
    s.cnt  = CW'(m_q.size());
    s.addr = m_pc;
    s.flt  = m_flt;
    st_q.push_back(s);
    if (rdy && m_q.size() > 0) exp_q.push_back(m_q[0]);
    model_step(rdy, br, tgt);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mon_en = 0;
    chk("sb_drained", 32'(exp_q.size() + st_q.size()), 32'd0);
    #2;
    rst_n            = 1'b0;
    bus.branch_taken = 1'b0;
    bus.dec_ready    = 1'b0;
    bus.branch_target = 32'd0;
    #1;
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    chk("rst_fault", {31'd0, bus.fault}, 32'd0);
    chk("rst_imem_address", bus.imem_address, RESET_PC);
    model_reset();
    exp_q.delete();
    st_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (st_q.size() > 0) begin
        mon_s = st_q.pop_front();
        chk("inst_valid", {31'd0, bus.inst_valid}, {31'd0, mon_s.vld});
        chk("fifo_count", 32'(bus.fifo_count), 32'(mon_s.cnt));
        chk("imem_address", bus.imem_address, mon_s.addr);
        chk("fault", {31'd0, bus.fault}, {31'd0, mon_s.flt});
      end
      if (bus.inst_valid && bus.dec_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL pop_unexpected: got inst_pc %h expected no pop at %0t", bus.inst_pc, $time);
        end else begin
          mon_pc = exp_q.pop_front();
          chk("inst_pc", bus.inst_pc, mon_pc);
          chk("inst", bus.inst, 32'hE000_0000 | mon_pc);
        end
      end
    end
  end

  initial begin
    logic [31:0] tgt;
    rst_n             = 1'b0;
    bus.dec_ready     = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;

    // Streaming after reset release.
    do_reset();
    repeat (6) cycle(1, 0, 32'd0);

    // Saturate at DEPTH, then pop and push on the same edge.
    do_reset();
    repeat (6) cycle(0, 0, 32'd0);
    repeat (3) cycle(1, 0, 32'd0);

    // Branch with three entries queued, unaligned target.
    do_reset();
    for (int i = 0; i < 8 && m_q.size() != 3; i++) cycle(0, 0, 32'd0);
    cycle(0, 1, 32'h101);
    repeat (5) cycle(1, 0, 32'd0);

    // Branch landing in the redirect bubble.
    cycle(1, 1, 32'h150);
    cycle(1, 1, 32'h200);
    repeat (4) cycle(1, 0, 32'd0);

    // Top-of-memory wrap (or fault when enabled), then drain.
    cycle(0, 1, 32'h3F8);
    repeat (6) cycle(0, 0, 32'd0);
    cycle(0, 1, 32'h040);
    repeat (6) cycle(1, 0, 32'd0);

`ifdef IMEM_FAULT_EN
    do_reset();
    repeat (3) cycle(1, 0, 32'd0);
    cycle(1, 1, 32'h102);
    repeat (3) cycle(1, 0, 32'd0);
    cycle(1, 1, 32'h080);
    repeat (3) cycle(1, 0, 32'd0);
`endif

    // Randomized traffic, each chunk started by a mid-cycle reset.
    for (int c = 0; c < 4; c++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        tgt = 32'($urandom_range(0, IMEM_BYTES - 1));
        if ($urandom_range(0, 9) == 0) tgt = $urandom();
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, tgt);
      end
    end

    mon_en = 0;
    chk("sb_final_drained", 32'(exp_q.size() + st_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
